// File: rtl/pwm_multi_dt_if.sv
// Control/status bundle between the register interface and the multi-channel PWM core.
interface pwm_multi_dt_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DT_WIDTH = 4
);
  logic                      enable;
  logic                      center;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [DT_WIDTH-1:0]       deadtime;
  logic                      load;
  logic [CHANNELS-1:0]       pwm_h;
  logic [CHANNELS-1:0]       pwm_l;
  logic                      period_tick;
  logic                      load_pending;

  modport master (
    output enable, center, period, duty, deadtime, load,
    input  pwm_h, pwm_l, period_tick, load_pending
  );

  modport slave (
    input  enable, center, period, duty, deadtime, load,
    output pwm_h, pwm_l, period_tick, load_pending
  );
endinterface

// File: rtl/pwm_multi_dt.sv
// Multi-channel PWM: shared edge/center-aligned counter, double-buffered
// period/duty/dead-time, complementary outputs with per-channel dead-time.
module pwm_multi_dt #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DT_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  pwm_multi_dt_if.slave   bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [WIDTH-1:0]    count_q, count_d;
  dir_e                dir_q, dir_d;
  logic                en_q, en_d;
  logic                pend_q, pend_d;
  logic [WIDTH-1:0]    per_q, per_d;
  logic                ctr_q, ctr_d;
  logic [DT_WIDTH-1:0] dt_q, dt_d;
  logic [WIDTH-1:0]    duty_q [CHANNELS];
  logic [WIDTH-1:0]    duty_d [CHANNELS];
  logic [CHANNELS-1:0] raw_q, raw_d;
  logic [DT_WIDTH-1:0] dt_cnt_q [CHANNELS];
  logic [DT_WIDTH-1:0] dt_cnt_d [CHANNELS];

  logic                boundary_c;
  logic                xfer_c;
  logic [WIDTH-1:0]    per_eff_c;
  logic                ctr_eff_c;
  logic [CHANNELS-1:0] pwm_h_c, pwm_l_c;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      per_q   <= '0;
      ctr_q   <= 1'b0;
      dt_q    <= '0;
      raw_q   <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        duty_q[i]   <= '0;
        dt_cnt_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      per_q   <= per_d;
      ctr_q   <= ctr_d;
      dt_q    <= dt_d;
      raw_q   <= raw_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        duty_q[i]   <= duty_d[i];
        dt_cnt_q[i] <= dt_cnt_d[i];
      end
    end
  end

  // Next state: shadow transfer, counter stepping, compare and dead-time
  always_comb begin
    count_d    = count_q;
    dir_d      = dir_q;
    en_d       = en_q;
    pend_d     = pend_q;
    per_d      = per_q;
    ctr_d      = ctr_q;
    dt_d       = dt_q;
    duty_d     = duty_q;
    raw_d      = raw_q;
    dt_cnt_d   = dt_cnt_q;
    boundary_c = (count_q == '0) && bus.enable && en_q;
    xfer_c     = boundary_c && (bus.load || pend_q);
    per_eff_c  = xfer_c ? bus.period : per_q;
    ctr_eff_c  = xfer_c ? bus.center : ctr_q;

    if (!bus.enable) begin
      // Idle: active registers track the shadow inputs
      count_d = '0;
      dir_d   = DIR_UP;
      en_d    = 1'b0;
      pend_d  = 1'b0;
      per_d   = bus.period;
      ctr_d   = bus.center;
      dt_d    = bus.deadtime;
      raw_d   = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        duty_d[i]   = bus.duty[i*WIDTH +: WIDTH];
        dt_cnt_d[i] = '0;
      end
    end else begin
      en_d = 1'b1;
      if (xfer_c) begin
        per_d  = bus.period;
        ctr_d  = bus.center;
        dt_d   = bus.deadtime;
        pend_d = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          duty_d[i] = bus.duty[i*WIDTH +: WIDTH];
        end
      end else if (bus.load) begin
        pend_d = 1'b1;
      end

      // Stepping uses the values that govern the following cycle
      if (!ctr_eff_c || (per_eff_c == '0)) begin
        dir_d   = DIR_UP;
        count_d = (count_q >= per_eff_c) ? '0 : count_q + WIDTH'(1);
      end else if ((dir_q == DIR_UP) && (count_q < per_eff_c)) begin
        dir_d   = DIR_UP;
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
        dir_d   = (count_q == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
      end

      for (int i = 0; i < int'(CHANNELS); i++) begin
        raw_d[i] = (count_q < duty_q[i]);
        if (raw_d[i] != raw_q[i]) begin
          dt_cnt_d[i] = dt_q;
        end else if (dt_cnt_q[i] != '0) begin
          dt_cnt_d[i] = dt_cnt_q[i] - DT_WIDTH'(1);
        end
      end
    end
  end

  // Complementary gate outputs, both held low while dead-time runs
  always_comb begin
    pwm_h_c = '0;
    pwm_l_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      pwm_h_c[i] = en_q &  raw_q[i] & (dt_cnt_q[i] == '0);
      pwm_l_c[i] = en_q & ~raw_q[i] & (dt_cnt_q[i] == '0);
    end
  end

  assign bus.pwm_h        = pwm_h_c;
  assign bus.pwm_l        = pwm_l_c;
  assign bus.period_tick  = boundary_c;
  assign bus.load_pending = pend_q;

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Self-checking bench for pwm_multi_dt: phase-based reference model plus directed windows.
module tb_pwm_multi_dt;
  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int DW  = 4;
  localparam int BIG = 1000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_dt_if #(.WIDTH(W), .CHANNELS(CH), .DT_WIDTH(DW)) bus ();

  pwm_multi_dt #(.WIDTH(W), .CHANNELS(CH), .DT_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the period plus per-channel time since last raw change
  int ph, m_per, m_dt;
  bit m_en, m_pend, m_ctr;
  int m_duty [CH];
  bit m_raw  [CH];
  int m_age  [CH];
  int m_dcap [CH];

  // Values observed at the latest compare
  bit last_tick, last_pend;
  logic [CH-1:0] last_h, last_l;
  int acc_h [CH];
  int acc_l [CH];
  int acc_tk;

  function automatic bit m_edge();
    return (!m_ctr || m_per == 0);
  endfunction

  function automatic int m_len();
    return m_edge() ? m_per + 1 : 2 * m_per;
  endfunction

  function automatic int m_count();
    if (m_edge()) return ph;
    return (ph <= m_per) ? ph : 2 * m_per - ph;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    ph = 0; m_en = 0; m_pend = 0; m_per = 0; m_ctr = 0; m_dt = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0; m_raw[i] = 0; m_age[i] = BIG; m_dcap[i] = 0;
    end
  endtask

  task automatic m_load_act();
    logic [CH*W-1:0] d;
    d = bus.duty;
    m_per = int'(bus.period);
    m_ctr = bus.center;
    m_dt  = int'(bus.deadtime);
    for (int i = 0; i < CH; i++) m_duty[i] = int'(d[i*W +: W]);
  endtask

  task automatic m_update();
    int  cnt;
    bit  xfer, nr;
    if (!reset) begin
      m_reset();
      return;
    end
    if (!bus.enable) begin
      ph = 0; m_en = 0; m_pend = 0;
      m_load_act();
      for (int i = 0; i < CH; i++) begin
        m_raw[i] = 0; m_age[i] = BIG; m_dcap[i] = 0;
      end
      return;
    end
    cnt  = m_count();
    xfer = (cnt == 0) && m_en && (bus.load || m_pend);
    for (int i = 0; i < CH; i++) begin
      nr = (cnt < m_duty[i]);
      if (nr != m_raw[i]) begin
        m_age[i]  = 0;
        m_dcap[i] = m_dt;
      end else if (m_age[i] < BIG) begin
        m_age[i]++;
      end
      m_raw[i] = nr;
    end
    if (xfer) begin
      m_load_act();
      m_pend = 0;
    end else if (bus.load) begin
      m_pend = 1;
    end
    ph   = (ph + 1) % m_len();
    m_en = 1;
  endtask

  // One cycle: compare DUT against model, advance model, move to next falling edge
  task automatic step();
    logic [CH-1:0] eh, el;
    bit etk;
    #1;
    for (int i = 0; i < CH; i++) begin
      eh[i] = m_en &&  m_raw[i] && (m_age[i] >= m_dcap[i]);
      el[i] = m_en && !m_raw[i] && (m_age[i] >= m_dcap[i]);
    end
    etk = bus.enable && m_en && (m_count() == 0);
    check("pwm_h",        int'(bus.pwm_h), int'(eh));
    check("pwm_l",        int'(bus.pwm_l), int'(el));
    check("period_tick",  int'(bus.period_tick), int'(etk));
    check("load_pending", int'(bus.load_pending), int'(m_pend));
    check("overlap",      int'(bus.pwm_h & bus.pwm_l), 0);
    last_tick = bus.period_tick;
    last_pend = bus.load_pending;
    last_h    = bus.pwm_h;
    last_l    = bus.pwm_l;
    for (int i = 0; i < CH; i++) begin
      acc_h[i] += int'(bus.pwm_h[i]);
      acc_l[i] += int'(bus.pwm_l[i]);
    end
    acc_tk += int'(bus.period_tick);
    m_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic window(input int n);
    for (int i = 0; i < CH; i++) begin
      acc_h[i] = 0; acc_l[i] = 0;
    end
    acc_tk = 0;
    run(n);
  endtask

  task automatic wait_tick(input string name);
    last_tick = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (last_tick) break;
    end
    check(name, int'(last_tick), 1);
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    bus.duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  // Idle for two cycles so the active registers pick up the inputs, then run
  task automatic setup(input int p, input bit ctr, input int d);
    bus.enable   = 1'b0;
    bus.period   = W'(p);
    bus.center   = ctr;
    bus.deadtime = DW'(d);
    bus.load     = 1'b0;
    run(2);
    bus.enable = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0; bus.center = 1'b0; bus.period = '0;
    bus.duty = '0; bus.deadtime = '0; bus.load = 1'b0;
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_pwm_h", int'(bus.pwm_h), 0);
    check("rst_pwm_l", int'(bus.pwm_l), 0);
    check("rst_tick",  int'(bus.period_tick), 0);
    check("rst_pend",  int'(bus.load_pending), 0);
    @(negedge clk);

    // Edge mode, P=9, duty 3, no dead-time
    set_duty(3, 0, 0, 0);
    setup(9, 1'b0, 0);
    run(20);
    window(10);
    check("t1_h0", acc_h[0], 3);
    check("t1_l0", acc_l[0], 7);
    check("t1_tick", acc_tk, 1);

    // Same with dead-time 2
    setup(9, 1'b0, 2);
    run(20);
    window(10);
    check("t2_h0", acc_h[0], 1);
    check("t2_l0", acc_l[0], 5);

    // 0% and 100% duty
    set_duty(0, 10, 0, 0);
    setup(9, 1'b0, 0);
    run(20);
    window(10);
    check("t3_h0", acc_h[0], 0);
    check("t3_l0", acc_l[0], 10);
    check("t3_h1", acc_h[1], 10);
    check("t3_l1", acc_l[1], 0);

    // Mid-period load is deferred to the next boundary
    set_duty(3, 0, 0, 0);
    setup(9, 1'b0, 0);
    run(20);
    wait_tick("t4_sync");
    run(3);
    set_duty(7, 0, 0, 0);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    check("t4_pend_set", int'(last_pend), 1);
    wait_tick("t4_boundary");
    check("t4_pend_at_tick", int'(last_pend), 1);
    step();
    check("t4_pend_clr", int'(last_pend), 0);
    run(10);
    window(10);
    check("t4_h0_new", acc_h[0], 7);

    // Center-aligned, P=4, duty 2
    set_duty(2, 0, 0, 0);
    setup(4, 1'b1, 0);
    run(20);
    window(8);
    check("t5_h0", acc_h[0], 3);
    check("t5_l0", acc_l[0], 5);
    check("t5_tick", acc_tk, 1);

    // Reset mid-period with a load pending
    set_duty(3, 0, 0, 0);
    setup(9, 1'b0, 0);
    run(24);
    set_duty(5, 0, 0, 0);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("t6_h", int'(last_h), 0);
    check("t6_l", int'(last_l), 0);
    check("t6_pend", int'(last_pend), 0);
    check("t6_tick", int'(last_tick), 0);
    run(15);

    // Randomized operation against the model
    set_duty(3, 4, 5, 6);
    setup(9, 1'b0, 1);
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom % 500 == 0) ? 1'b0 : 1'b1;
      if ($urandom % 150 == 0) bus.enable = ~bus.enable;
      if ($urandom % 40 == 0)
        bus.period = ($urandom % 8 == 0) ? W'(255) : W'($urandom_range(0, 12));
      if ($urandom % 60 == 0) bus.center = ~bus.center;
      if ($urandom % 15 == 0) begin
        for (int i = 0; i < CH; i++) begin
          logic [CH*W-1:0] d;
          d = bus.duty;
          d[i*W +: W] = ($urandom % 10 == 0) ? W'(255) : W'($urandom_range(0, 14));
          bus.duty = d;
        end
      end
      if ($urandom % 50 == 0) bus.deadtime = DW'($urandom_range(0, 15));
      bus.load = ($urandom % 12 == 0);
      if (!bus.enable && ($urandom % 20 == 0)) bus.enable = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
